conv1_window_buf_8b: RTL and testbench

- Line buffer and 3x3 window generator that feeds the binarized conv1 calculator.
- Accepts a raster-order 8-bit MNIST pixel stream, one pixel per valid beat.
- Emits the nine window pixels plus a one-cycle valid strobe for every valid-convolution position.
- No padding: 26x26 windows per 28x28 frame.

---
 rtl/conv1_window_buf_8b.sv | 142 ++++++++++++++
 tb/tb_conv1_window_buf_8b.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/conv1_window_buf_8b.sv
// conv1_window_buf_8b
//   Line buffer and 3x3 window generator in front of the binarized conv1
//   calculator. Takes a raster-order pixel stream (one pixel per valid_in
//   beat, gaps allowed, no backpressure) and emits the nine window pixels
//   plus a one-cycle strobe for every valid-convolution position. There is
//   no padding, so a 28x28 frame yields 26x26 windows.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset, highest priority
//   valid_in       pixel_in carries an accepted pixel this cycle
//   pixel_in       unsigned pixel, row-major raster order
//   pixel_0..8     window, row-major (pixel_0 top-left, pixel_8 bottom-right)
//   valid_out_buf  window outputs valid (single-cycle pulse)
//   frame_done     one-cycle pulse after the last pixel of a frame

module conv1_window_buf_8b #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] pixel_in,
   output logic [DATA_W-1:0] pixel_0,
   output logic [DATA_W-1:0] pixel_1,
   output logic [DATA_W-1:0] pixel_2,
   output logic [DATA_W-1:0] pixel_3,
   output logic [DATA_W-1:0] pixel_4,
   output logic [DATA_W-1:0] pixel_5,
   output logic [DATA_W-1:0] pixel_6,
   output logic [DATA_W-1:0] pixel_7,
   output logic [DATA_W-1:0] pixel_8,
   output logic              valid_out_buf,
   output logic              frame_done
);

   // sr_q[k] holds the pixel accepted k+1 beats ago, so the oldest entry
   // (index 2*IMG_W+1) is the top-left of the window for the current pixel.
   localparam int SR_DEPTH = 2*IMG_W + 2;
   localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [DATA_W-1:0] sr_q  [SR_DEPTH];
   logic [DATA_W-1:0] sr_d  [SR_DEPTH];
   logic [DATA_W-1:0] win_q [9];
   logic [DATA_W-1:0] win_d [9];
   logic              valid_q, valid_d;
   logic              done_q, done_d;

   logic last_col;
   logic last_row;
   logic qualify;

   assign last_col = (col_q == COL_W'(IMG_W-1));
   assign last_row = (row_q == ROW_W'(IMG_H-1));

   // Rows 0/1 and columns 0/1 would pull in pixels from the previous row or
   // frame, so only positions with r>=2 and c>=2 produce a window.
   assign qualify  = valid_in && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (valid_in) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_comb begin
      sr_d = sr_q;
      if (valid_in) begin
         sr_d[0] = pixel_in;
         for (int i = 1; i < SR_DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
         end
      end
   end

   // The current pixel comes straight from pixel_in; the other eight taps
   // are read from storage before it shifts.
   always_comb begin
      win_d = win_q;
      if (qualify) begin
         win_d[8] = pixel_in;
         win_d[7] = sr_q[0];
         win_d[6] = sr_q[1];
         win_d[5] = sr_q[IMG_W-1];
         win_d[4] = sr_q[IMG_W];
         win_d[3] = sr_q[IMG_W+1];
         win_d[2] = sr_q[2*IMG_W-1];
         win_d[1] = sr_q[2*IMG_W];
         win_d[0] = sr_q[2*IMG_W+1];
      end
   end

   assign valid_d = qualify;
   assign done_d  = valid_in && last_col && last_row;

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < SR_DEPTH; i++) begin
            sr_q[i] <= '0;
         end
         for (int i = 0; i < 9; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         sr_q    <= sr_d;
         win_q   <= win_d;
      end
   end

   assign pixel_0       = win_q[0];
   assign pixel_1       = win_q[1];
   assign pixel_2       = win_q[2];
   assign pixel_3       = win_q[3];
   assign pixel_4       = win_q[4];
   assign pixel_5       = win_q[5];
   assign pixel_6       = win_q[6];
   assign pixel_7       = win_q[7];
   assign pixel_8       = win_q[8];
   assign valid_out_buf = valid_q;
   assign frame_done    = done_q;

endmodule

// File: tb/tb_conv1_window_buf_8b.sv
// Directed testbench for conv1_window_buf_8b. Drives ramp and inverted-ramp
// frames (continuous and with idle gaps), mid-frame and power-on resets, and
// checks every cycle's outputs against expectations computed from stream
// indices.

module tb_conv1_window_buf_8b;

   localparam int IMG_W = 28;
   localparam int IMG_H = 28;
   localparam int NPIX  = IMG_W * IMG_H;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid_in = 1'b0;
   logic [7:0] pixel_in = 8'h00;
   logic [7:0] pixel_0, pixel_1, pixel_2, pixel_3, pixel_4;
   logic [7:0] pixel_5, pixel_6, pixel_7, pixel_8;
   logic       valid_out_buf;
   logic       frame_done;

   int vectors     = 0;
   int miscompares = 0;
   int pulses      = 0;
   int done_cnt    = 0;

   logic [71:0] last_win = '0;

   conv1_window_buf_8b #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .valid_in      (valid_in),
      .pixel_in      (pixel_in),
      .pixel_0       (pixel_0),
      .pixel_1       (pixel_1),
      .pixel_2       (pixel_2),
      .pixel_3       (pixel_3),
      .pixel_4       (pixel_4),
      .pixel_5       (pixel_5),
      .pixel_6       (pixel_6),
      .pixel_7       (pixel_7),
      .pixel_8       (pixel_8),
      .valid_out_buf (valid_out_buf),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [71:0] win_obs();
      return {pixel_0, pixel_1, pixel_2, pixel_3, pixel_4,
              pixel_5, pixel_6, pixel_7, pixel_8};
   endfunction

   function automatic logic [7:0] pix(input int mode, input int idx);
      if (mode == 1) return 8'(255 - (idx % 256));
      return 8'(idx % 256);
   endfunction

   // Window for the pixel at stream index n, pixel_0 in the top byte.
   function automatic logic [71:0] win_exp(input int mode, input int n);
      return {pix(mode, n-2*IMG_W-2), pix(mode, n-2*IMG_W-1), pix(mode, n-2*IMG_W),
              pix(mode, n-IMG_W-2),   pix(mode, n-IMG_W-1),   pix(mode, n-IMG_W),
              pix(mode, n-2),         pix(mode, n-1),         pix(mode, n)};
   endfunction

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] p, input logic r_in);
      rst      = r_in;
      valid_in = v;
      pixel_in = p;
      @(posedge clk);
      #1;
      if (valid_out_buf === 1'b1) pulses++;
      if (frame_done === 1'b1) done_cnt++;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " valid"}, 72'(valid_out_buf), 72'd0);
      chk({tag, " done"},  72'(frame_done),    72'd0);
      chk({tag, " hold"},  win_obs(),          last_win);
   endtask

   task automatic chk_reset(input string tag);
      last_win = '0;
      chk_idle(tag);
   endtask

   // Sends pixels 0..last_n of a frame; with gaps set, up to four idle
   // cycles (each with 25% probability) precede every accepted pixel.
   task automatic run_frame(input int mode, input bit gaps, input int last_n);
      for (int n = 0; n <= last_n; n++) begin
         int r;
         int c;
         bit exp_v;
         if (gaps) begin
            for (int k = 0; k < 4; k++) begin
               if ($urandom_range(0, 3) != 0) break;
               step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
               chk_idle("gap");
            end
         end
         step(1'b1, pix(mode, n), 1'b0);
         r     = n / IMG_W;
         c     = n % IMG_W;
         exp_v = (r >= 2) && (c >= 2);
         chk("valid_out_buf", 72'(valid_out_buf), 72'(exp_v));
         chk("frame_done", 72'(frame_done), 72'(n == NPIX-1));
         if (exp_v) last_win = win_exp(mode, n);
         chk("window", win_obs(), last_win);
         if (n == 58 && mode == 0)
            chk("first ramp window", win_obs(),
                {8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58});
         if (n == 58 && mode == 1)
            chk("first inv window p0/p8", {pixel_0, pixel_8}, {8'd255, 8'd197});
      end
   endtask

   initial begin
      // Power-on reset with valid_in and a pattern held on the input.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'hAA, 1'b1);
         chk_reset("por");
      end

      // Continuous ramp frame, then check the final window and frame_done.
      pulses = 0; done_cnt = 0;
      run_frame(0, 1'b0, NPIX-1);
      chk("last p0", 72'(pixel_0), 72'd213);
      chk("last p4", 72'(pixel_4), 72'd242);
      chk("last p8", 72'(pixel_8), 72'd15);
      chk("last frame_done", 72'(frame_done), 72'd1);

      // Inverted frame back-to-back with the ramp.
      run_frame(1, 1'b0, NPIX-1);
      chk("pulses two frames", 72'(pulses), 72'd1352);
      chk("frame_done count", 72'(done_cnt), 72'd2);

      // Ramp with random idle gaps.
      pulses = 0; done_cnt = 0;
      run_frame(0, 1'b1, NPIX-1);
      chk("pulses gapped", 72'(pulses), 72'd676);
      chk("done gapped", 72'(done_cnt), 72'd1);

      // Reset after n=300, then a fresh full ramp frame.
      run_frame(0, 1'b0, 300);
      step(1'b1, 8'hAA, 1'b1);
      chk_reset("midrst");
      pulses = 0; done_cnt = 0;
      run_frame(0, 1'b0, NPIX-1);
      chk("pulses after reset", 72'(pulses), 72'd676);
      chk("done after reset", 72'(done_cnt), 72'd1);

      step(1'b0, 8'h00, 1'b0);
      chk_idle("tail");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
